// File: rtl/usart_pkg.sv
// Shared types and encodings for the USART transmit path.
// The PARITY state exists only when USART_TX_PARITY_EN is defined.
package usart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef USART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP1,
    ST_STOP2
  } tx_state_e;

  localparam logic [2:0] UCSZ_5 = 3'b000;
  localparam logic [2:0] UCSZ_6 = 3'b001;
  localparam logic [2:0] UCSZ_7 = 3'b010;
  localparam logic [2:0] UCSZ_8 = 3'b011;
  localparam logic [2:0] UCSZ_9 = 3'b111;

  localparam logic [1:0] UPM_NONE = 2'b00;
  localparam logic [1:0] UPM_RSVD = 2'b01;
  localparam logic [1:0] UPM_EVEN = 2'b10;
  localparam logic [1:0] UPM_ODD  = 2'b11;

  // Index of the last data bit; reserved sizes fall back to 8 bits.
  function automatic logic [3:0] ucsz_len_m1(input logic [2:0] ucsz);
    case (ucsz)
      UCSZ_5:  ucsz_len_m1 = 4'd4;
      UCSZ_6:  ucsz_len_m1 = 4'd5;
      UCSZ_7:  ucsz_len_m1 = 4'd6;
      UCSZ_8:  ucsz_len_m1 = 4'd7;
      UCSZ_9:  ucsz_len_m1 = 4'd8;
      default: ucsz_len_m1 = 4'd7;
    endcase
  endfunction

endpackage

// File: rtl/usart_tx_shift.sv
// Transmit shift register: holds one frame's data bits, shifts LSB first,
// and flags when the bit currently on the line is the last data bit.
module usart_tx_shift (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic       i_shift,
  input  logic [8:0] i_data,
  input  logic [3:0] i_len_m1,
  output logic       o_bit,
  output logic       o_next,
  output logic       o_done
);

  logic [8:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] len_m1_q, len_m1_d;

  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    len_m1_d = len_m1_q;
    if (i_load) begin
      sr_d     = i_data;
      cnt_d    = 4'd0;
      len_m1_d = i_len_m1;
    end else if (i_shift) begin
      sr_d  = {1'b0, sr_q[8:1]};
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      len_m1_q <= '0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      len_m1_q <= len_m1_d;
    end
  end

  assign o_bit  = sr_q[0];
  assign o_next = sr_q[1];
  assign o_done = (cnt_q == len_m1_q);

endmodule

// File: rtl/usart_tx.sv
// USART transmit engine: UDR holding register, frame FSM and status flags.
// Parity generation is built only when USART_TX_PARITY_EN is defined.
module usart_tx
  import usart_pkg::*;
(
  input  logic       i_fosk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_txen,
  input  logic       i_we_udr,
  input  logic [7:0] i_udr,
  input  logic       i_tx8,
  input  logic [2:0] i_ucsz,
  input  logic [1:0] i_upm,
  input  logic       i_usbs,
  output logic       o_txd,
  output logic       o_udre,
  output logic       o_txc,
  output logic       o_busy
);

  tx_state_e  state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       udre_q, udre_d;
  logic       txc_q, txc_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       usbs_q, usbs_d;

  logic       sh_load, sh_shift, sh_bit, sh_next, sh_done;
  logic [3:0] len_m1;
  logic [8:0] load_data;
  logic       wr_ok, xfer, frame_end;

  assign len_m1    = ucsz_len_m1(i_ucsz);
  // Bits above the word length are zeroed so parity sees only real data.
  assign load_data = {i_tx8, hold_q} & ~(9'h1FE << len_m1);
  assign wr_ok     = i_we_udr & udre_q;

`ifdef USART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_upm;
  assign unused_upm = ^i_upm;
`endif

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    udre_d    = udre_q;
    txc_d     = txc_q;
    txd_d     = txd_q;
    usbs_d    = usbs_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    xfer      = 1'b0;
    frame_end = 1'b0;
`ifdef USART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif

    if (wr_ok) begin
      hold_d = i_udr;
      udre_d = 1'b0;
    end

    if (i_tick) begin
      case (state_q)
        ST_IDLE: xfer = ~udre_q & i_txen;
        ST_START: begin
          state_d = ST_DATA;
          txd_d   = sh_bit;
        end
        ST_DATA: begin
          if (!sh_done) begin
            sh_shift = 1'b1;
            txd_d    = sh_next;
          end
`ifdef USART_TX_PARITY_EN
          else if (par_en_q) begin
            state_d = ST_PARITY;
            txd_d   = par_bit_q;
          end
`endif
          else begin
            state_d = ST_STOP1;
            txd_d   = 1'b1;
          end
        end
`ifdef USART_TX_PARITY_EN
        ST_PARITY: begin
          state_d = ST_STOP1;
          txd_d   = 1'b1;
        end
`endif
        ST_STOP1: begin
          if (usbs_q) begin
            state_d = ST_STOP2;
            txd_d   = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
        end
        ST_STOP2: frame_end = 1'b1;
        default: begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end

    // A pending byte chains straight on, even after TXEN drops.
    if (frame_end) begin
      if (!udre_q) begin
        xfer = 1'b1;
      end else begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        txc_d   = 1'b1;
      end
    end

    if (xfer) begin
      sh_load = 1'b1;
      state_d = ST_START;
      txd_d   = 1'b0;
      udre_d  = 1'b1;
      usbs_d  = i_usbs;
`ifdef USART_TX_PARITY_EN
      par_en_d  = i_upm[1];
      par_bit_d = (^load_data) ^ (i_upm == UPM_ODD);
`endif
    end

    if (wr_ok) begin
      txc_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_fosk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      udre_q  <= 1'b1;
      txc_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      usbs_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      udre_q  <= udre_d;
      txc_q   <= txc_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      usbs_q  <= usbs_d;
    end
  end

`ifdef USART_TX_PARITY_EN
  always_ff @(posedge i_fosk or posedge i_rst) begin
    if (i_rst) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end
`endif

  usart_tx_shift u_shift (
    .i_clk    (i_fosk),
    .i_rst    (i_rst),
    .i_load   (sh_load),
    .i_shift  (sh_shift),
    .i_data   (load_data),
    .i_len_m1 (len_m1),
    .o_bit    (sh_bit),
    .o_next   (sh_next),
    .o_done   (sh_done)
  );

  assign o_txd  = txd_q;
  assign o_udre = udre_q;
  assign o_txc  = txc_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_usart_tx.sv
// Directed bench for usart_tx: frame formats, double buffering, TXEN and reset.
module tb_usart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       txen;
  logic       we;
  logic [7:0] udr;
  logic       tx8;
  logic [2:0] ucsz;
  logic [1:0] upm;
  logic       usbs;
  logic       txd, udre, txc, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  usart_tx dut (
    .i_fosk   (clk),
    .i_rst    (rst),
    .i_tick   (tick),
    .i_txen   (txen),
    .i_we_udr (we),
    .i_udr    (udr),
    .i_tx8    (tx8),
    .i_ucsz   (ucsz),
    .i_upm    (upm),
    .i_usbs   (usbs),
    .o_txd    (txd),
    .o_udre   (udre),
    .o_txc    (txc),
    .o_busy   (busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One baud tick, seen by exactly one rising edge; returns on the following falling edge.
  task automatic tick_pulse();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic write_udr(input logic [7:0] b);
    @(negedge clk);
    udr = b;
    we  = 1'b1;
    @(negedge clk);
    we  = 1'b0;
  endtask

  // bits[0] is the first bit expected on the line.
  task automatic send_bits(input logic [15:0] bits, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick_pulse();
      chk($sformatf("%s[%0d]", tag, i), txd, bits[i]);
    end
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    txen = 1'b1;
    we   = 1'b0;
    udr  = 8'h00;
    tx8  = 1'b0;
    ucsz = 3'b011;
    upm  = 2'b00;
    usbs = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_udre", udre, 1'b1);
    chk("rst_txc", txc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    tick_pulse();
    chk("idle_tick_txd", txd, 1'b1);
    chk("idle_tick_busy", busy, 1'b0);

    // 8N1, 0x55
    write_udr(8'h55);
    chk("8n1_udre_wr", udre, 1'b0);
    send_bits({1'b1, 8'h55, 1'b0}, 10, "8n1");
    chk("8n1_busy", busy, 1'b1);
    chk("8n1_txc_stop", txc, 1'b0);
    tick_pulse();
    chk("8n1_end_txd", txd, 1'b1);
    chk("8n1_end_txc", txc, 1'b1);
    chk("8n1_end_busy", busy, 1'b0);

    // 9-bit, even parity, two stop bits
    ucsz = 3'b111; upm = 2'b10; usbs = 1'b1; tx8 = 1'b1;
    write_udr(8'h01);
    chk("9e2_txc_clr", txc, 1'b0);
`ifdef USART_TX_PARITY_EN
    send_bits({2'b11, 1'b0, 9'h101, 1'b0}, 13, "9e2");
`else
    send_bits({2'b11, 9'h101, 1'b0}, 12, "9e2");
`endif
    chk("9e2_txc_stop", txc, 1'b0);
    tick_pulse();
    chk("9e2_end_txd", txd, 1'b1);
    chk("9e2_end_txc", txc, 1'b1);

    // Double buffering, 8N1
    ucsz = 3'b011; upm = 2'b00; usbs = 1'b0; tx8 = 1'b0;
    write_udr(8'hA0);
    tick_pulse();
    chk("db_a0_start", txd, 1'b0);
    chk("db_udre_xfer", udre, 1'b1);
    write_udr(8'h0F);
    chk("db_udre_pend", udre, 1'b0);
    send_bits({1'b1, 8'hA0}, 9, "db_a0");
    chk("db_udre_stop", udre, 1'b0);
    tick_pulse();
    chk("db_0f_start", txd, 1'b0);
    chk("db_udre_chain", udre, 1'b1);
    chk("db_txc_chain", txc, 1'b0);
    send_bits({1'b1, 8'h0F}, 9, "db_0f");
    chk("db_txc_stop", txc, 1'b0);
    tick_pulse();
    chk("db_end_txd", txd, 1'b1);
    chk("db_end_txc", txc, 1'b1);

    // 5-bit odd parity; upper byte bits must not reach the line or the parity
    ucsz = 3'b000; upm = 2'b11;
    write_udr(8'hFF);
`ifdef USART_TX_PARITY_EN
    send_bits({1'b1, 1'b0, 5'h1F, 1'b0}, 8, "5o1");
`else
    send_bits({1'b1, 5'h1F, 1'b0}, 7, "5o1");
`endif
    tick_pulse();
    chk("5o1_end_txd", txd, 1'b1);
    chk("5o1_end_txc", txc, 1'b1);

    // TXEN dropped mid-frame with one byte pending
    ucsz = 3'b011; upm = 2'b00;
    write_udr(8'h3C);
    tick_pulse();
    chk("txen_start", txd, 1'b0);
    write_udr(8'hC3);
    send_bits(16'h0000, 1, "txen_b0");
    txen = 1'b0;
    send_bits({1'b1, 7'b0011110}, 8, "txen_3c");
    tick_pulse();
    chk("txen_c3_start", txd, 1'b0);
    chk("txen_udre", udre, 1'b1);
    send_bits({1'b1, 8'hC3}, 9, "txen_c3");
    tick_pulse();
    chk("txen_end_txc", txc, 1'b1);
    chk("txen_end_busy", busy, 1'b0);
    write_udr(8'h5A);
    tick_pulse();
    tick_pulse();
    chk("txen_blk_txd", txd, 1'b1);
    chk("txen_blk_busy", busy, 1'b0);
    chk("txen_blk_udre", udre, 1'b0);
    txen = 1'b1;
    tick_pulse();
    chk("txen_re_start", txd, 1'b0);
    chk("txen_re_udre", udre, 1'b1);

    // Asynchronous reset during DATA with a byte pending
    send_bits(16'h0000, 1, "rst_b0");
    write_udr(8'h77);
    chk("rst_pre_udre", udre, 1'b0);
    chk("rst_pre_busy", busy, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_txd", txd, 1'b1);
    chk("arst_udre", udre, 1'b1);
    chk("arst_txc", txc, 1'b0);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    write_udr(8'h81);
    send_bits({1'b1, 8'h81, 1'b0}, 10, "post_rst");
    tick_pulse();
    chk("post_rst_txc", txc, 1'b1);
    chk("post_rst_txd", txd, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
